clk_rst_seq: RTL and testbench



---
 rtl/clk_rst_seq_pkg.sv | 18 +
 rtl/clk_rst_sync_bit.sv | 28 ++
 rtl/clk_rst_seq.sv | 143 ++++++++++++++
 tb/tb_clk_rst_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_seq_pkg.sv
// Shared state encoding and default sizing for the reset sequencer.
// Latency: n/a. Backpressure: n/a.
// Flow control: none (package only).
package clk_rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_DOM     = 4;
    localparam int DEF_HOLD_CYCLES = 1024;
    localparam int DEF_STAGE_GAP   = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_rst_sync_bit.sv
// Single-bit multi-flop synchronizer for an asynchronous level input.
// Latency: SYNC_STAGES clk cycles. Backpressure: none.
// Flops clear to 0 so a lock is never seen as present coming out of reset.
module clk_rst_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// Staged per-domain reset release once all clock locks are stable; aborts on lock loss or SW request.
// Latency: first release HOLD_CYCLES after all locks seen, then one domain per STAGE_GAP cycles.
// Backpressure: none; lock-loss counter saturates at 255.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk_csr,
    input  logic               rst_csr_n,
    input  logic [NUM_DOM-1:0] lock_in,
    input  logic               sw_rst_req,
    input  logic               lock_loss_clr,
    output logic [NUM_DOM-1:0] rst_n_out,
    output logic               seq_done,
    output logic [1:0]         seq_state,
    output logic [NUM_DOM-1:0] lock_sync,
    output logic [7:0]         lock_loss_cnt
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] rst_q, rst_d;
    logic               done_q, done_d;
    logic               all_lock;
    logic               lock_lost;
    logic               abort;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_sync
        clk_rst_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk_csr),
            .rst_n(rst_csr_n),
            .d    (lock_in[g]),
            .q    (lock_sync[g])
        );
    end

    assign all_lock  = &lock_sync;
    // Missing locks are only a loss event once the sequence has started.
    assign lock_lost = (state_q != WAIT_LOCK) && !all_lock;
    assign abort     = lock_lost || sw_rst_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        if (abort) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_d = '0;
                    if (all_lock) begin
                        state_d = STABLE;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                STABLE: begin
                    if (cnt_q == '0) begin
                        state_d  = RELEASE;
                        rst_d[0] = 1'b1;
                        idx_d    = '0;
                        cnt_d    = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d        = idx_q + 1'b1;
                        rst_d[idx_d] = 1'b1;
                        cnt_d        = GAP_LOAD;
                    end
                end
                RUN: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    rst_d   = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_csr or negedge rst_csr_n) begin
        if (!rst_csr_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // Clear beats a coincident increment; SW aborts never count.
    always_ff @(posedge clk_csr or negedge rst_csr_n) begin
        if (!rst_csr_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_loss_clr) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end

    assign rst_n_out = rst_q;
    assign seq_done  = done_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Randomized + directed bench for clk_rst_seq with a scoreboard fed by an elapsed-time reference model.
module tb_clk_rst_seq;

    localparam int N = 4;
    localparam int H = 8;
    localparam int G = 4;

    typedef struct packed {
        logic [3:0] rst;
        logic       done;
        logic [1:0] st;
        logic [3:0] sync;
        logic [7:0] cnt;
    } exp_t;

    logic       clk_csr;
    logic       rst_csr_n;
    logic [3:0] lock_in;
    logic       sw_rst_req;
    logic       lock_loss_clr;
    logic [3:0] rst_n_out;
    logic       seq_done;
    logic [1:0] seq_state;
    logic [3:0] lock_sync;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    exp_t       exp_q[$];
    logic [3:0] sync_pipe[$];
    bit         m_active;
    int         m_elapsed;
    int         m_cnt;
    exp_t       mon_e;

    clk_rst_seq #(
        .NUM_DOM    (N),
        .HOLD_CYCLES(H),
        .STAGE_GAP  (G),
        .SYNC_STAGES(2)
    ) dut (
        .clk_csr      (clk_csr),
        .rst_csr_n    (rst_csr_n),
        .lock_in      (lock_in),
        .sw_rst_req   (sw_rst_req),
        .lock_loss_clr(lock_loss_clr),
        .rst_n_out    (rst_n_out),
        .seq_done     (seq_done),
        .seq_state    (seq_state),
        .lock_sync    (lock_sync),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial begin
        clk_csr = 1'b0;
        forever #5 clk_csr = ~clk_csr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sync_pipe.delete();
        sync_pipe.push_back(4'h0);
        sync_pipe.push_back(4'h0);
        m_active  = 1'b0;
        m_elapsed = 0;
        m_cnt     = 0;
    endtask

    // Sequence is described by time elapsed since entering the hold phase:
    // domain k is out of reset once H + k*G cycles have passed, done after H + N*G.
    task automatic model_step();
        logic [3:0] seen;
        bit         lost;
        exp_t       e;
        seen = sync_pipe.pop_front();
        sync_pipe.push_back(lock_in);
        lost = m_active && (seen != 4'hF);
        if (m_active) begin
            if (lost || sw_rst_req) m_active = 1'b0;
            else m_elapsed++;
        end else if ((seen == 4'hF) && !sw_rst_req) begin
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        if (lock_loss_clr) m_cnt = 0;
        else if (lost && m_cnt < 255) m_cnt++;
        e = '0;
        if (m_active) begin
            for (int k = 0; k < N; k++) e.rst[k] = (m_elapsed >= H + k * G);
            e.done = (m_elapsed >= H + N * G);
            e.st   = (m_elapsed < H) ? 2'd1 : (e.done ? 2'd3 : 2'd2);
        end
        e.sync = sync_pipe[0];
        e.cnt  = m_cnt[7:0];
        exp_q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_csr);
        @(negedge clk_csr);
    endtask

    task automatic hold_reset();
        rst_csr_n = 1'b0;
        repeat (3) @(negedge clk_csr);
        rst_csr_n = 1'b1;
        model_reset();
    endtask

    task automatic check_nominal(input string tag);
        logic [3:0] er;
        lock_in = 4'hF;
        for (int j = 1; j <= 28; j++) begin
            tick();
            er = '0;
            for (int k = 0; k < N; k++) if (j - 1 >= 10 + 4 * k) er[k] = 1'b1;
            chk({tag, " rst_n_out"}, rst_n_out, er);
            chk({tag, " seq_done"}, seq_done, (j - 1 >= 26) ? 1 : 0);
        end
        chk({tag, " state_run"}, seq_state, 3);
    endtask

    always @(posedge clk_csr) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("model", {rst_n_out, seq_done, seq_state, lock_sync, lock_loss_cnt}, mon_e);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int low_left;
        int b;
        rst_csr_n     = 1'b0;
        lock_in       = 4'h0;
        sw_rst_req    = 1'b0;
        lock_loss_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_csr);
        chk("reset rst_n_out", rst_n_out, 0);
        chk("reset seq_done", seq_done, 0);
        chk("reset seq_state", seq_state, 0);
        chk("reset lock_sync", lock_sync, 0);
        chk("reset lock_loss_cnt", lock_loss_cnt, 0);
        rst_csr_n = 1'b1;

        repeat (3) tick();
        chk("idle no release", rst_n_out, 0);
        chk("idle no count", lock_loss_cnt, 0);

        check_nominal("nominal");

        // Lock loss while running.
        lock_in[3] = 1'b0;
        tick();
        chk("loss edge0 rst", rst_n_out, 4'hF);
        tick();
        chk("loss edge1 rst", rst_n_out, 4'hF);
        tick();
        chk("loss abort rst", rst_n_out, 0);
        chk("loss abort state", seq_state, 0);
        chk("loss abort done", seq_done, 0);
        chk("loss abort cnt", lock_loss_cnt, 1);
        lock_in = 4'hF;
        repeat (40) tick();
        chk("relock run", seq_state, 3);

        // Software restart while running.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw abort rst", rst_n_out, 0);
        chk("sw abort state", seq_state, 0);
        chk("sw abort cnt", lock_loss_cnt, 1);
        for (int j = 1; j <= 25; j++) begin
            tick();
            chk("sw reseq done", seq_done, (j >= 25) ? 1 : 0);
        end

        // Asynchronous reset in the middle of release, idx=1.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        repeat (15) tick();
        chk("mid release rst", rst_n_out, 4'b0011);
        chk("mid release state", seq_state, 2);
        #2;
        rst_csr_n = 1'b0;
        #1;
        chk("async rst_n_out", rst_n_out, 0);
        chk("async seq_state", seq_state, 0);
        chk("async lock_sync", lock_sync, 0);
        chk("async cnt", lock_loss_cnt, 0);
        @(negedge clk_csr);
        hold_reset();
        check_nominal("post reset");

        // Glitch while holding.
        lock_in = 4'h0;
        @(negedge clk_csr);
        hold_reset();
        lock_in = 4'hF;
        for (int j = 1; j <= 20; j++) begin
            if (j == 6) lock_in[2] = 1'b0;
            if (j == 9) lock_in = 4'hF;
            tick();
            chk("glitch rst", rst_n_out, (j >= 19) ? 4'b0001 : 4'b0000);
        end
        chk("glitch cnt", lock_loss_cnt, 1);

        // Saturation with repeated lock-loss aborts.
        for (int n = 0; n < 300; n++) begin
            b = $urandom_range(0, 3);
            lock_in    = 4'hF;
            lock_in[b] = 1'b0;
            tick();
            lock_in = 4'hF;
            repeat ($urandom_range(2, 5)) tick();
        end
        repeat (3) tick();
        chk("saturate cnt", lock_loss_cnt, 255);

        // Clear coincident with an abort.
        repeat (4) tick();
        lock_in[1] = 1'b0;
        tick();
        lock_in = 4'hF;
        tick();
        lock_loss_clr = 1'b1;
        tick();
        lock_loss_clr = 1'b0;
        chk("clr vs abort cnt", lock_loss_cnt, 0);
        chk("clr vs abort state", seq_state, 0);

        // Random traffic against the model.
        low_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if (low_left > 0) begin
                low_left--;
            end else begin
                lock_in = 4'hF;
                if ($urandom_range(0, 39) == 0) begin
                    b = $urandom_range(0, 3);
                    lock_in[b] = 1'b0;
                    low_left = $urandom_range(0, 3);
                end
            end
            sw_rst_req    = ($urandom_range(0, 89) == 0);
            lock_loss_clr = ($urandom_range(0, 119) == 0);
            tick();
        end
        sw_rst_req    = 1'b0;
        lock_loss_clr = 1'b0;
        lock_in       = 4'hF;
        repeat (40) tick();
        chk("final run", seq_state, 3);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
